// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the datapath bus.
//   - Source index map matching the existing CPU ordering.
//   - Default data width and source count.
//   - sel_width(): width of the encoded select code (never below 1).
package bus_pkg;

    localparam int unsigned BUS_WIDTH  = 32;
    localparam int unsigned BUS_N_SRC  = 25;

    // General-purpose registers occupy 0..15 (SRC_R0 + n).
    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_R15    = 15;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHI    = 18;
    localparam int unsigned SRC_ZLO    = 19;
    localparam int unsigned SRC_ZMUX   = 20;
    localparam int unsigned SRC_PC     = 21;
    localparam int unsigned SRC_MDR    = 22;
    localparam int unsigned SRC_INPORT = 23;
    localparam int unsigned SRC_CSIGN  = 24;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// bus_prio_enc: combinational fixed-priority encoder (highest index wins).
//   vec   : request vector, normally one-hot or zero
//   idx   : index of the highest set bit (0 when none set)
//   any   : at least one bit set
//   multi : two or more bits set
module bus_prio_enc #(
    parameter int unsigned N     = 25,
    parameter int unsigned SEL_W = 5
) (
    input  logic [N-1:0]     vec,
    output logic [SEL_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx = '0;
        // Ascending scan: the last match (highest index) overrides earlier ones.
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = SEL_W'(i);
            end
        end
    end

    assign any   = |vec;
    // Clearing the lowest set bit leaves something only if 2+ bits were set.
    assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// bus_mux_reg: registered priority bus multiplexer with conflict monitoring.
//   clock, clear       : rising-edge clock, async active-high reset
//   src_data           : packed sources, source i at [i*WIDTH +: WIDTH]
//   src_out            : per-source drive enables
//   status_clr         : sync clear of conflict_sticky / conflict_count
//   bus_out            : bus value (registered when REG_OUT=1)
//   sel_code           : winning source index
//   bus_valid          : bus_out reflects a source driven in this transfer
//   conflict           : 1-cycle pulse when 2+ enables were active
//   conflict_sticky    : latched conflict flag
//   conflict_count     : saturating count of conflict cycles
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH        = BUS_WIDTH,
    parameter int unsigned N_SRC        = BUS_N_SRC,
    parameter int unsigned SEL_W        = sel_width(N_SRC),
    parameter bit          REG_OUT      = 1'b1,
    parameter bit          HOLD_ON_IDLE = 1'b1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic [N_SRC-1:0]       src_out,
    input  logic                   status_clr,
    output logic [WIDTH-1:0]       bus_out,
    output logic [SEL_W-1:0]       sel_code,
    output logic                   bus_valid,
    output logic                   conflict,
    output logic                   conflict_sticky,
    output logic [CNT_W-1:0]       conflict_count
);

    logic [SEL_W-1:0] win_idx;
    logic             any_active;
    logic             multi;
    logic [WIDTH-1:0] win_data;

    logic [WIDTH-1:0] bus_q;
    logic [SEL_W-1:0] sel_q;
    logic             valid_q;
    logic             conflict_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;

    bus_prio_enc #(
        .N     (N_SRC),
        .SEL_W (SEL_W)
    ) u_enc (
        .vec   (src_out),
        .idx   (win_idx),
        .any   (any_active),
        .multi (multi)
    );

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (win_idx == SEL_W'(i)) begin
                win_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // bus_q is the output register when REG_OUT=1 and the hold register when
    // REG_OUT=0; the update rule is identical in both modes.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (any_active) begin
            bus_q   <= win_data;
            sel_q   <= win_idx;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            if (!HOLD_ON_IDLE) begin
                bus_q <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            conflict_q <= multi;
            sticky_q   <= (sticky_q | multi) & ~status_clr;
            if (status_clr) begin
                count_q <= '0;
            end else if (multi && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        if (REG_OUT) begin
            bus_out   = bus_q;
            sel_code  = sel_q;
            bus_valid = valid_q;
        end else if (clear) begin
            // Combinational path must still read zero while in reset.
            bus_out   = '0;
            sel_code  = '0;
            bus_valid = 1'b0;
        end else begin
            bus_valid = any_active;
            sel_code  = any_active ? win_idx : sel_q;
            if (any_active) begin
                bus_out = win_data;
            end else if (HOLD_ON_IDLE) begin
                bus_out = bus_q;
            end else begin
                bus_out = '0;
            end
        end
    end

    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_count  = count_q;

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the CPU's datapath bus multiplexer/encoder.
- It selects one of N_SRC WIDTH-bit sources onto the shared bus using per-source "out" enables, and exports the encoded select code.
- It adds capabilities the previous bus lacked:
  - an optional output register;
  - an explicit hold-last-value policy when no source is driving;
  - multi-driver conflict detection with a sticky flag and a saturating counter.
- It sits between the register file, special registers (HI/LO/Z/PC/MDR/in-port/C-sign) and all bus consumers.

Parameters:
- WIDTH, 32: bus data width in bits.
- N_SRC, 25: number of bus sources.
- SEL_W, $clog2(N_SRC): width of the encoded select code.
- REG_OUT, 1: 1 = bus output registered (1-cycle latency); 0 = combinational data path, status still registered.
- HOLD_ON_IDLE, 1: 1 = bus keeps its last driven value when no enable is active; 0 = bus drives all-zero when idle.
- CNT_W, 8: width of the saturating conflict counter.

Ports:
- clock, input, 1: rising-edge clock.
- clear, input, 1: asynchronous active-high reset.
- src_data, input, N_SRC*WIDTH: packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- src_out, input, N_SRC: per-source drive enables; intended one-hot or zero.
- status_clr, input, 1: synchronous clear of conflict_sticky and conflict_count.
- bus_out, output, WIDTH: bus value.
- sel_code, output, SEL_W: index of the winning source; registered when REG_OUT=1.
- bus_valid, output, 1: 1 when bus_out reflects a source driven in the current transfer.
- conflict, output, 1: 1-cycle pulse, asserted when two or more enables were active.
- conflict_sticky, output, 1: set by any conflict; cleared only by clear or status_clr.
- conflict_count, output, CNT_W: number of conflict cycles, saturating at all-ones.

Behaviour:
- Reset:
  - While clear=1 (asynchronous, immediate), all of the following are 0: bus_out, sel_code, bus_valid, conflict, conflict_sticky, conflict_count, and the hold register.
  - This holds even if reset is asserted mid-transfer.
- Selection:
  - The highest-index active enable wins (fixed priority: source N_SRC-1 highest).
  - Combinational priority encode yields win_idx and any_active = |src_out.
  - multi = 2 or more bits of src_out set (popcount > 1, or equivalently src_out & (src_out-1) != 0).
- Data path when REG_OUT=1, on each rising edge:
  - if any_active: bus_out <= src_data[win_idx]; sel_code <= win_idx; bus_valid <= 1.
  - else: bus_valid <= 0; sel_code holds; bus_out holds if HOLD_ON_IDLE=1, else bus_out <= 0.
  - Latency: exactly 1 cycle from enable to bus_out.
- Data path when REG_OUT=0:
  - bus_out, sel_code and bus_valid are combinational from the current inputs.
  - The idle value is the registered last-driven value if HOLD_ON_IDLE=1, else 0.
  - The hold register updates every cycle in which any_active=1.
- Status (always registered, regardless of REG_OUT):
  - conflict <= multi.
  - conflict_sticky <= (conflict_sticky | multi) & ~status_clr.
  - conflict_count: if status_clr, set to 0; else if multi and count != all-ones, increment; else hold. The count saturates at 2^CNT_W-1 with no wrap.
- Simultaneous status_clr and multi in the same cycle: the clear takes priority. After that edge, sticky=0 and count=0, but the conflict pulse is still 1.
- Conflicts never block the transfer. The winning source is still delivered and bus_valid=1.
- No handshake: the bus accepts new enables every cycle, and back-to-back transfers each occupy one cycle.
- N_SRC=1 is legal: SEL_W is forced to 1, sel_code stays 0, and conflict stays 0.
- Unused sel_code codes (values >= N_SRC) never appear on the output.

Decomposition:
- Shared package bus_pkg contains:
  - source-index localparams matching the existing CPU ordering: SRC_R0..SRC_R15=0..15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_ZMUX=20, SRC_PC=21, SRC_MDR=22, SRC_INPORT=23, SRC_CSIGN=24;
  - the default WIDTH and N_SRC values.
- One sub-module: bus_prio_enc, parametrised N and SEL_W.
  - Inputs: a one-hot-ish vector.
  - Outputs: idx, any, multi.
  - Purely combinational; reused by the top and by the bench's reference model.

Test Plan:
1. Reset and idle: assert clear mid-cycle with src_out=0 -> all outputs become 0 immediately; after release, bus_valid stays 0 and bus_out stays 0.
2. Single drive, REG_OUT=1:
   - src_data[SRC_PC]=32'h0000_1234 and src_out=1<<21 for one cycle -> on the next edge, bus_out=32'h0000_1234, sel_code=21, bus_valid=1.
   - src_out=0 on the following cycle -> bus_out holds 32'h0000_1234 and bus_valid=0.
   - Repeat with HOLD_ON_IDLE=0 -> bus_out=0 on the idle cycle.
3. Conflict priority:
   - Drive R3=32'hAAAA_AAAA and MDR=32'h5555_5555 in the same cycle -> bus_out=32'h5555_5555, sel_code=22, conflict pulses 1 for exactly one cycle, conflict_sticky=1, conflict_count=1.
4. Back-to-back transfers: R0=1, R1=2, R2=3 enabled on consecutive cycles -> bus_out is 1, 2, 3 on consecutive cycles, with no bubbles and bus_valid continuously 1.
5. Counter saturation and clear:
   - Run 300 consecutive conflict cycles with CNT_W=8 -> count stops at 255.
   - Assert status_clr together with a conflict -> count=0, sticky=0, conflict=1.
6. REG_OUT=0:
   - src_out=1<<SRC_LO with data 32'hDEAD_BEEF -> bus_out=32'hDEAD_BEEF in the same cycle, with no clock edge needed.
   - Drop the enable -> the held value 32'hDEAD_BEEF remains and bus_valid=0.
